// File: rtl/shell_ballistics_pkg.sv
// Shared types and screen constants for the tank shell ballistics block.
package shell_ballistics_pkg;

  typedef enum logic [1:0] {IDLE, FLIGHT, IMPACT} shell_state_t;

  localparam int X_MAX    = 639;
  localparam int Y_MAX    = 479;
  localparam int GROUND_Y = 440;

  // Launch vy is always upward (negative), magnitude limited to vmax.
  function automatic logic signed [5:0] clamp_vy(input logic [9:0] yc,
                                                 input int shift,
                                                 input int vmax);
    logic [9:0] mag;
    mag = yc >> shift;
    if (mag > 10'(vmax)) mag = 10'(vmax);
    return -$signed(6'(mag));
  endfunction

endpackage

// File: rtl/shell_hit_detect.sv
// Combinational axis-aligned box overlap on signed 11b operands.
module shell_hit_detect (
  input  logic signed [10:0] ax,
  input  logic signed [10:0] ay,
  input  logic signed [10:0] bx,
  input  logic signed [10:0] by,
  input  logic        [10:0] reach,
  output logic               overlap
);

  // One extra bit so the difference of two 11b values never wraps.
  logic signed [11:0] dx, dy;
  logic        [11:0] adx, ady;

  always_comb begin
    dx      = {ax[10], ax} - {bx[10], bx};
    dy      = {ay[10], ay} - {by[10], by};
    adx     = dx[11] ? 12'(-dx) : 12'(dx);
    ady     = dy[11] ? 12'(-dy) : 12'(dy);
    overlap = (adx <= {1'b0, reach}) && (ady <= {1'b0, reach});
  end

endmodule

// File: rtl/shell_ballistics.sv
// One tank's shell: fire edge capture, frame-stepped gravity flight, enemy hit / miss.
module shell_ballistics
  import shell_ballistics_pkg::*;
#(
  parameter int VX_SPEED       = 2,
  parameter int VY_SHIFT       = 1,
  parameter int VY_MAX         = 15,
  parameter int GRAVITY        = 1,
  parameter int GRAV_DIV       = 4,
  parameter int SHELL_R        = 2,
  parameter int EXPLODE_FRAMES = 16
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       currentState,
  input  logic       shoot,
  input  logic [1:0] Direction,
  input  logic [9:0] y_component,
  input  logic [9:0] ShooterX,
  input  logic [9:0] ShooterY,
  input  logic [9:0] ShooterS,
  input  logic [9:0] EnemyX,
  input  logic [9:0] EnemyY,
  input  logic [9:0] EnemyS,
  output logic [9:0] ShellX,
  output logic [9:0] ShellY,
  output logic       shell_visible,
  output logic       exploding,
  output logic       busy,
  output logic       hit,
  output logic       miss
);

  localparam int GW = (GRAV_DIV > 1) ? $clog2(GRAV_DIV) : 1;
  localparam int EW = (EXPLODE_FRAMES > 1) ? $clog2(EXPLODE_FRAMES) : 1;
  localparam logic signed [10:0] GY   = 11'(GROUND_Y);
  localparam logic signed [10:0] XMX  = 11'(X_MAX);
  localparam logic signed [5:0]  VX   = 6'(VX_SPEED);
  localparam logic signed [6:0]  VYMX = 7'(VY_MAX);

  shell_state_t       state;
  logic               shoot_q;
  logic signed [10:0] sx, sy;
  logic signed [5:0]  vx, vy;
  logic [GW-1:0]      gcnt;
  logic [EW-1:0]      ecnt;

  logic               fire, box_hit, out_of_bounds, checking;
  logic signed [6:0]  vy_sum;
  logic signed [5:0]  vy_grav;
  logic        [10:0] reach;

  assign fire  = shoot & ~shoot_q;
  assign reach = {1'b0, EnemyS} + 11'(SHELL_R);

  shell_hit_detect u_hit (
    .ax      (sx),
    .ay      (sy),
    .bx      ($signed({1'b0, EnemyX})),
    .by      ($signed({1'b0, EnemyY})),
    .reach   (reach),
    .overlap (box_hit)
  );

  assign out_of_bounds = (sy >= GY) || (sx < 0) || (sx > XMX);

  // Pulses are decoded from the registered shell position; leaving play suppresses them.
  assign checking = (state == FLIGHT) && currentState;
  assign hit      = checking && box_hit;
  assign miss     = checking && !box_hit && out_of_bounds;

  assign vy_sum  = {vy[5], vy} + 7'(GRAVITY);
  assign vy_grav = (vy_sum > VYMX) ? 6'(VY_MAX) : vy_sum[5:0];

  assign ShellX        = sx[9:0];
  assign ShellY        = sy[10] ? 10'd0 : sy[9:0];
  assign shell_visible = (state == FLIGHT) && !sy[10];
  assign exploding     = (state == IMPACT);
  assign busy          = (state != IDLE);

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state   <= IDLE;
      shoot_q <= 1'b0;
      sx      <= '0;
      sy      <= '0;
      vx      <= '0;
      vy      <= '0;
      gcnt    <= '0;
      ecnt    <= '0;
    end else begin
      shoot_q <= shoot;
      if (!currentState) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (fire) begin
            state <= FLIGHT;
            sx    <= $signed({1'b0, ShooterX});
            sy    <= $signed({1'b0, ShooterY}) - $signed({1'b0, ShooterS}) - 11'(SHELL_R);
            vx    <= (Direction == 2'd0) ? -VX : VX;
            vy    <= clamp_vy(y_component, VY_SHIFT, VY_MAX);
            gcnt  <= '0;
          end
          FLIGHT: begin
            if (box_hit || out_of_bounds) begin
              state <= IMPACT;
              ecnt  <= '0;
            end else begin
              sx <= sx + $signed({{5{vx[5]}}, vx});
              sy <= sy + $signed({{5{vy[5]}}, vy});
              if (gcnt == GW'(GRAV_DIV - 1)) begin
                gcnt <= '0;
                vy   <= vy_grav;
              end else begin
                gcnt <= gcnt + 1'b1;
              end
            end
          end
          IMPACT: begin
            if (ecnt == EW'(EXPLODE_FRAMES - 1)) state <= IDLE;
            else                                 ecnt  <= ecnt + 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_shell_ballistics.sv
// Directed bench for shell_ballistics with hand-computed trajectories.
module tb_shell_ballistics;

  logic       frame_clk = 1'b0;
  logic       Reset, currentState, shoot;
  logic [1:0] Direction;
  logic [9:0] y_component, ShooterX, ShooterY, ShooterS, EnemyX, EnemyY, EnemyS;
  logic [9:0] ShellX, ShellY;
  logic       shell_visible, exploding, busy, hit, miss;

  int checks = 0;
  int errors = 0;

  shell_ballistics dut (
    .frame_clk    (frame_clk),
    .Reset        (Reset),
    .currentState (currentState),
    .shoot        (shoot),
    .Direction    (Direction),
    .y_component  (y_component),
    .ShooterX     (ShooterX),
    .ShooterY     (ShooterY),
    .ShooterS     (ShooterS),
    .EnemyX       (EnemyX),
    .EnemyY       (EnemyY),
    .EnemyS       (EnemyS),
    .ShellX       (ShellX),
    .ShellY       (ShellY),
    .shell_visible(shell_visible),
    .exploding    (exploding),
    .busy         (busy),
    .hit          (hit),
    .miss         (miss)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic tick;
    @(posedge frame_clk);
    #1;
  endtask

  // Leaves DUT in IDLE with shoot low and a far-away enemy.
  task automatic settle;
    shoot = 0; currentState = 0; tick();
    currentState = 1; tick();
    EnemyX = 1000; EnemyY = 1000; EnemyS = 0;
  endtask

  // Returns one sample after the launch edge (cycle N+1).
  task automatic launch(input int x, input int y, input int s, input int dir, input int yc);
    ShooterX = 10'(x); ShooterY = 10'(y); ShooterS = 10'(s);
    Direction = 2'(dir); y_component = 10'(yc);
    shoot = 0; tick();
    shoot = 1; tick();
  endtask

  task automatic test_reset;
    Reset = 1; tick(); tick();
    checks++;
    if ({ShellX, ShellY, shell_visible, exploding, busy, hit, miss} !== 25'd0) begin
      errors++;
      $display("FAIL reset_outputs got x=%0d y=%0d v%b e%b b%b h%b m%b want all 0",
               ShellX, ShellY, shell_visible, exploding, busy, hit, miss);
    end
    Reset = 0; tick();
  endtask

  task automatic test_launch;
    settle();
    launch(50, 200, 4, 1, 0);
    shoot = 0;
    checks++;
    if (ShellX !== 10'd50 || ShellY !== 10'd194 || busy !== 1'b1 || shell_visible !== 1'b1) begin
      errors++;
      $display("FAIL launch_pos got x=%0d y=%0d b%b v%b want 50 194 1 1", ShellX, ShellY, busy, shell_visible);
    end
    tick();
    checks++;
    if (ShellX !== 10'd52) begin errors++; $display("FAIL first_step got %0d want 52", ShellX); end
    tick(); tick(); tick();
    checks++;
    if (ShellX !== 10'd58 || ShellY !== 10'd194) begin
      errors++; $display("FAIL after4 got x=%0d y=%0d want 58 194", ShellX, ShellY);
    end
    tick();
    checks++;
    if (ShellY !== 10'd195) begin errors++; $display("FAIL gravity_vy1 got y=%0d want 195", ShellY); end
  endtask

  task automatic test_launch_vy;
    settle();
    launch(50, 200, 4, 1, 9); shoot = 0; tick();
    checks++;
    if (ShellY !== 10'd190) begin errors++; $display("FAIL vy_shift got %0d want 190", ShellY); end
    settle();
    launch(50, 200, 4, 1, 40); shoot = 0; tick();
    checks++;
    if (ShellY !== 10'd179) begin errors++; $display("FAIL vy_clamp got %0d want 179", ShellY); end
    settle();
    launch(50, 20, 4, 1, 1023); shoot = 0;
    checks++;
    if (ShellY !== 10'd14 || shell_visible !== 1'b1) begin
      errors++; $display("FAIL high_launch got y=%0d v%b want 14 1", ShellY, shell_visible);
    end
    tick();
    checks++;
    if (ShellY !== 10'd0 || shell_visible !== 1'b0 || busy !== 1'b1 || miss !== 1'b0) begin
      errors++;
      $display("FAIL above_screen got y=%0d v%b b%b m%b want 0 0 1 0", ShellY, shell_visible, busy, miss);
    end
  endtask

  task automatic test_hit;
    int expl;
    settle();
    EnemyX = 60; EnemyY = 194; EnemyS = 4;
    launch(50, 200, 4, 1, 0); shoot = 0;
    checks++;
    if (hit !== 1'b0) begin errors++; $display("FAIL hit_early_n1 got %b want 0", hit); end
    tick();
    checks++;
    if (hit !== 1'b0) begin errors++; $display("FAIL hit_early_n2 got %b want 0", hit); end
    tick();
    checks++;
    if (hit !== 1'b1 || miss !== 1'b0 || ShellX !== 10'd54) begin
      errors++; $display("FAIL hit_pulse got h%b m%b x=%0d want 1 0 54", hit, miss, ShellX);
    end
    tick();
    checks++;
    if (hit !== 1'b0 || exploding !== 1'b1 || ShellX !== 10'd54) begin
      errors++; $display("FAIL hit_width got h%b e%b x=%0d want 0 1 54", hit, exploding, ShellX);
    end
    expl = 1;
    for (int i = 0; i < 40 && busy; i++) begin
      tick();
      if (exploding) expl++;
    end
    checks++;
    if (expl !== 16 || busy !== 1'b0) begin
      errors++; $display("FAIL explode_len got %0d busy=%b want 16 0", expl, busy);
    end
  endtask

  task automatic test_ground;
    int early;
    settle();
    launch(300, 440, 0, 0, 0); shoot = 0;
    tick();
    checks++;
    if (ShellX !== 10'd298) begin errors++; $display("FAIL left_step got %0d want 298", ShellX); end
    early = 0;
    for (int i = 0; i < 4; i++) begin
      if (miss || hit) early++;
      tick();
    end
    checks++;
    if (early !== 0) begin errors++; $display("FAIL ground_early got %0d pulses want 0", early); end
    tick();
    checks++;
    if (miss !== 1'b1 || hit !== 1'b0 || ShellY !== 10'd440 || ShellX !== 10'd288) begin
      errors++;
      $display("FAIL ground_miss got m%b h%b x=%0d y=%0d want 1 0 288 440", miss, hit, ShellX, ShellY);
    end
    tick();
    checks++;
    if (miss !== 1'b0 || exploding !== 1'b1) begin
      errors++; $display("FAIL miss_width got m%b e%b want 0 1", miss, exploding);
    end
  endtask

  task automatic test_hold_shoot;
    settle();
    launch(630, 200, 4, 2, 0);
    tick();
    shoot = 0; tick();
    shoot = 1; tick();
    checks++;
    if (ShellX !== 10'd636 || busy !== 1'b1) begin
      errors++; $display("FAIL refire_in_flight got x=%0d b%b want 636 1", ShellX, busy);
    end
    tick(); tick();
    checks++;
    if (miss !== 1'b1 || ShellX !== 10'd640) begin
      errors++; $display("FAIL right_edge_miss got m%b x=%0d want 1 640", miss, ShellX);
    end
    for (int i = 0; i < 30; i++) tick();
    checks++;
    if (busy !== 1'b0 || exploding !== 1'b0) begin
      errors++; $display("FAIL held_shoot_relaunch got b%b e%b want 0 0", busy, exploding);
    end
    shoot = 0;
  endtask

  task automatic test_abort;
    settle();
    EnemyX = 54; EnemyY = 194; EnemyS = 0;
    launch(50, 200, 4, 1, 0); shoot = 0;
    tick();
    currentState = 0; #1;
    checks++;
    if (hit !== 1'b0 || miss !== 1'b0) begin
      errors++; $display("FAIL abort_pulse got h%b m%b want 0 0", hit, miss);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || hit !== 1'b0 || exploding !== 1'b0) begin
      errors++; $display("FAIL abort_idle got b%b h%b e%b want 0 0 0", busy, hit, exploding);
    end
    currentState = 1;
  endtask

  task automatic test_right_edge;
    settle();
    launch(636, 200, 4, 1, 0); shoot = 0;
    tick();
    checks++;
    if (miss !== 1'b0) begin errors++; $display("FAIL edge_early got %b want 0", miss); end
    tick();
    checks++;
    if (miss !== 1'b1 || ShellX !== 10'd640) begin
      errors++; $display("FAIL edge_miss got m%b x=%0d want 1 640", miss, ShellX);
    end
  endtask

  task automatic test_reset_mid_flight;
    settle();
    launch(50, 200, 4, 1, 0); shoot = 0;
    tick(); tick();
    Reset = 1; tick();
    checks++;
    if ({ShellX, ShellY, shell_visible, exploding, busy, hit, miss} !== 25'd0) begin
      errors++;
      $display("FAIL reset_mid got x=%0d y=%0d v%b e%b b%b h%b m%b want all 0",
               ShellX, ShellY, shell_visible, exploding, busy, hit, miss);
    end
    tick();
    Reset = 0; tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_release got b%b want 0", busy); end
  endtask

  initial begin
    Reset = 1; currentState = 1; shoot = 0; Direction = 1; y_component = 0;
    ShooterX = 0; ShooterY = 0; ShooterS = 0;
    EnemyX = 1000; EnemyY = 1000; EnemyS = 0;
    test_reset();
    test_launch();
    test_launch_vy();
    test_hit();
    test_ground();
    test_hold_shoot();
    test_abort();
    test_right_edge();
    test_reset_mid_flight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
